// File: rtl/single_cycle_core.sv
`default_nettype none
// ============================================================================
// Module      : single_cycle_core
// Description : Single-cycle 32-bit MIPS-subset datapath. Combinational
//               fetch from a loadable instruction ROM, decode/ALU/branch
//               logic, a 256-word data memory, a 32x32 register file and
//               the PC register. One instruction retires per rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module single_cycle_core #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rstd,
  input  logic        imem_we,
  input  logic [7:0]  imem_addr,
  input  logic [31:0] imem_wdata,
  output logic [31:0] pc,
  output logic [31:0] ins,
  output logic [31:0] reg1,
  output logic [31:0] reg2,
  output logic [4:0]  wra,
  output logic [31:0] result
);

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  // Opcodes
  localparam logic [5:0] c_op_rtype = 6'd0;
  localparam logic [5:0] c_op_j     = 6'd2;
  localparam logic [5:0] c_op_jal   = 6'd3;
  localparam logic [5:0] c_op_beq   = 6'd4;
  localparam logic [5:0] c_op_bne   = 6'd5;
  localparam logic [5:0] c_op_addi  = 6'd8;
  localparam logic [5:0] c_op_slti  = 6'd10;
  localparam logic [5:0] c_op_andi  = 6'd12;
  localparam logic [5:0] c_op_ori   = 6'd13;
  localparam logic [5:0] c_op_xori  = 6'd14;
  localparam logic [5:0] c_op_lui   = 6'd15;
  localparam logic [5:0] c_op_lw    = 6'd35;
  localparam logic [5:0] c_op_sw    = 6'd43;

  // R-type function codes
  localparam logic [5:0] c_fn_sll = 6'd0;
  localparam logic [5:0] c_fn_srl = 6'd2;
  localparam logic [5:0] c_fn_sra = 6'd3;
  localparam logic [5:0] c_fn_jr  = 6'd8;
  localparam logic [5:0] c_fn_add = 6'd32;
  localparam logic [5:0] c_fn_sub = 6'd34;
  localparam logic [5:0] c_fn_and = 6'd36;
  localparam logic [5:0] c_fn_or  = 6'd37;
  localparam logic [5:0] c_fn_xor = 6'd38;
  localparam logic [5:0] c_fn_nor = 6'd39;
  localparam logic [5:0] c_fn_slt = 6'd42;

  // Storage
  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] dmem [DMEM_DEPTH];
  logic [31:0] rf   [32];

  // Instruction fields
  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_shamt;
  logic [5:0]  w_funct;
  logic [15:0] w_imm;
  logic [25:0] w_jaddr;
  logic [31:0] w_sext;
  logic [31:0] w_zext;

  // Execute-stage helpers
  logic [31:0]    w_pc_plus1;
  logic [31:0]    w_branch_target;
  logic [31:0]    w_next_pc;
  logic [DAW-1:0] w_mem_addr;
  logic           w_dmem_we;
  logic           w_slt_rr;
  logic           w_slt_ri;
  logic           w_equal;

  // Fetch is purely combinational from the current PC
  assign ins = imem[pc[IAW-1:0]];

  assign w_op    = ins[31:26];
  assign w_rs    = ins[25:21];
  assign w_rt    = ins[20:16];
  assign w_rd    = ins[15:11];
  assign w_shamt = ins[10:6];
  assign w_funct = ins[5:0];
  assign w_imm   = ins[15:0];
  assign w_jaddr = ins[25:0];
  assign w_sext  = {{16{w_imm[15]}}, w_imm};
  assign w_zext  = {16'd0, w_imm};

  // Asynchronous register reads; register 0 is hardwired to zero
  assign reg1 = (w_rs == 5'd0) ? 32'd0 : rf[w_rs];
  assign reg2 = (w_rt == 5'd0) ? 32'd0 : rf[w_rt];

  assign w_pc_plus1      = pc + 32'd1;
  assign w_branch_target = w_pc_plus1 + w_sext;
  // Only the low address bits select a data word, so add just those bits
  assign w_mem_addr      = reg1[DAW-1:0] + w_sext[DAW-1:0];
  assign w_slt_rr        = $signed(reg1) < $signed(reg2);
  assign w_slt_ri        = $signed(reg1) < $signed(w_sext);
  assign w_equal         = (reg1 == reg2);

  // Decode and execute: ALU result, writeback target, store enable and next PC
  always_comb begin
    w_next_pc = w_pc_plus1;
    wra       = 5'd0;
    result    = 32'd0;
    w_dmem_we = 1'b0;
    case (w_op)
      c_op_rtype: begin
        wra = w_rd;
        case (w_funct)
          c_fn_add: result = reg1 + reg2;
          c_fn_sub: result = reg1 - reg2;
          c_fn_and: result = reg1 & reg2;
          c_fn_or:  result = reg1 | reg2;
          c_fn_xor: result = reg1 ^ reg2;
          c_fn_nor: result = ~(reg1 | reg2);
          c_fn_slt: result = {31'd0, w_slt_rr};
          c_fn_sll: result = reg2 << w_shamt;
          c_fn_srl: result = reg2 >> w_shamt;
          c_fn_sra: result = $signed(reg2) >>> w_shamt;
          c_fn_jr: begin
            w_next_pc = reg1;
            wra       = 5'd0;
          end
          default:  wra = 5'd0;
        endcase
      end
      c_op_addi: begin
        wra    = w_rt;
        result = reg1 + w_sext;
      end
      c_op_slti: begin
        wra    = w_rt;
        result = {31'd0, w_slt_ri};
      end
      c_op_andi: begin
        wra    = w_rt;
        result = reg1 & w_zext;
      end
      c_op_ori: begin
        wra    = w_rt;
        result = reg1 | w_zext;
      end
      c_op_xori: begin
        wra    = w_rt;
        result = reg1 ^ w_zext;
      end
      c_op_lui: begin
        wra    = w_rt;
        result = {w_imm, 16'd0};
      end
      c_op_lw: begin
        wra    = w_rt;
        result = dmem[w_mem_addr];
      end
      c_op_sw: begin
        w_dmem_we = 1'b1;
      end
      c_op_beq: begin
        if (w_equal) w_next_pc = w_branch_target;
      end
      c_op_bne: begin
        if (!w_equal) w_next_pc = w_branch_target;
      end
      c_op_j: begin
        w_next_pc = {pc[31:26], w_jaddr};
      end
      c_op_jal: begin
        w_next_pc = {pc[31:26], w_jaddr};
        wra       = 5'd31;
        result    = w_pc_plus1;
      end
      default: begin
        w_next_pc = w_pc_plus1;
      end
    endcase
  end

  // PC register: reset to word 0, otherwise follow the computed next PC
  always_ff @(posedge clk) begin
    if (rstd) begin
      pc <= 32'd0;
    end else begin
      pc <= w_next_pc;
    end
  end

  // Register file writeback; reset clears every register and wins over writeback
  always_ff @(posedge clk) begin
    if (rstd) begin
      for (int i = 0; i < 32; i++) begin
        rf[i] <= 32'd0;
      end
    end else if (wra != 5'd0) begin
      rf[wra] <= result;
    end
  end

  // Data memory store port; a store is suppressed while reset is asserted
  always_ff @(posedge clk) begin
    if (w_dmem_we && !rstd) begin
      dmem[w_mem_addr] <= reg2;
    end
  end

  // Instruction memory program-load port, independent of reset
  always_ff @(posedge clk) begin
    if (imem_we) begin
      imem[imem_addr[IAW-1:0]] <= imem_wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_single_cycle_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_single_cycle_core
// Description : Self-checking bench for single_cycle_core. An ISA-level
//               model (PC, register array, memory arrays) predicts every
//               output each cycle; directed programs pin literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_single_cycle_core;

  logic        clk = 1'b0;
  logic        rstd;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [31:0] pc;
  logic [31:0] ins;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic [4:0]  wra;
  logic [31:0] result;

  always #5 clk = ~clk;

  single_cycle_core dut (
    .clk        (clk),
    .rstd       (rstd),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .pc         (pc),
    .ins        (ins),
    .reg1       (reg1),
    .reg2       (reg2),
    .wra        (wra),
    .result     (result)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Architectural model state
  logic [31:0] m_pc;
  logic [31:0] m_rf   [32];
  logic [31:0] m_imem [256];
  logic [31:0] m_dmem [256];

  // Model predictions for the current cycle
  logic [31:0] e_ins, e_r1, e_r2, e_res, e_npc;
  logic [4:0]  e_wra;
  bit          e_st;
  logic [7:0]  e_sa;

  // Directed program and its literal expectations
  logic [31:0] prog[$];
  logic [31:0] xpc[$];
  logic [31:0] xwra[$];
  logic [31:0] xres[$];

  function automatic logic [31:0] f_r(int rs, int rt, int rd, int sh, int fn);
    return {6'd0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
  endfunction

  function automatic logic [31:0] f_i(int op, int rs, int rt, int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] f_j(int op, int addr);
    return {op[5:0], addr[25:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Predict this cycle's behaviour from the instruction-set rules
  task automatic model_eval();
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm;
    logic [31:0] sx, zx, ea;
    e_ins = m_imem[m_pc[7:0]];
    op  = e_ins[31:26];
    rs  = e_ins[25:21];
    rt  = e_ins[20:16];
    rd  = e_ins[15:11];
    sh  = e_ins[10:6];
    fn  = e_ins[5:0];
    imm = e_ins[15:0];
    sx  = {{16{imm[15]}}, imm};
    zx  = {16'd0, imm};
    e_r1 = m_rf[rs];
    e_r2 = m_rf[rt];
    ea   = e_r1 + sx;
    e_sa = ea[7:0];
    e_npc = m_pc + 1;
    e_wra = 0;
    e_res = 0;
    e_st  = 0;
    case (op)
      0: begin
        e_wra = rd;
        case (fn)
          32: e_res = e_r1 + e_r2;
          34: e_res = e_r1 - e_r2;
          36: e_res = e_r1 & e_r2;
          37: e_res = e_r1 | e_r2;
          38: e_res = e_r1 ^ e_r2;
          39: e_res = ~(e_r1 | e_r2);
          42: e_res = ($signed(e_r1) < $signed(e_r2)) ? 32'd1 : 32'd0;
          0:  e_res = e_r2 << sh;
          2:  e_res = e_r2 >> sh;
          3:  e_res = $signed(e_r2) >>> sh;
          8:  begin e_npc = e_r1; e_wra = 0; end
          default: e_wra = 0;
        endcase
      end
      8:  begin e_wra = rt; e_res = e_r1 + sx; end
      10: begin e_wra = rt; e_res = ($signed(e_r1) < $signed(sx)) ? 32'd1 : 32'd0; end
      12: begin e_wra = rt; e_res = e_r1 & zx; end
      13: begin e_wra = rt; e_res = e_r1 | zx; end
      14: begin e_wra = rt; e_res = e_r1 ^ zx; end
      15: begin e_wra = rt; e_res = {imm, 16'd0}; end
      35: begin e_wra = rt; e_res = m_dmem[e_sa]; end
      43: e_st = 1;
      4:  if (e_r1 == e_r2) e_npc = m_pc + 1 + sx;
      5:  if (e_r1 != e_r2) e_npc = m_pc + 1 + sx;
      2:  e_npc = {m_pc[31:26], e_ins[25:0]};
      3:  begin e_npc = {m_pc[31:26], e_ins[25:0]}; e_wra = 31; e_res = m_pc + 1; end
      default: ;
    endcase
  endtask

  // One clock: drive inputs, compare DUT against the model, advance both
  task automatic tick(input bit rs, input bit we, input int a, input logic [31:0] d);
    rstd       = rs;
    imem_we    = we;
    imem_addr  = a[7:0];
    imem_wdata = d;
    model_eval();
    if (chk_en) begin
      check("pc", pc, m_pc);
      check("ins", ins, e_ins);
      check("reg1", reg1, e_r1);
      check("reg2", reg2, e_r2);
      check("wra", 32'(wra), 32'(e_wra));
      if (e_wra != 0) check("result", result, e_res);
    end
    @(posedge clk);
    if (we) m_imem[a[7:0]] = d;
    if (rs) begin
      m_pc = 0;
      for (int i = 0; i < 32; i++) m_rf[i] = 0;
    end else begin
      if (e_st) m_dmem[e_sa] = e_r2;
      if (e_wra != 0) m_rf[e_wra] = e_res;
      m_pc = e_npc;
    end
    @(negedge clk);
  endtask

  task automatic load_prog();
    for (int i = 0; i < prog.size(); i++) tick(1, 1, i, prog[i]);
    tick(1, 0, 0, 0);
  endtask

  task automatic run_lit(input string tag);
    for (int i = 0; i < xpc.size(); i++) begin
      check({tag, "_pc"}, pc, xpc[i]);
      check({tag, "_wra"}, 32'(wra), xwra[i]);
      if (xwra[i] != 0) check({tag, "_res"}, result, xres[i]);
      tick(0, 0, 0, 0);
    end
  endtask

  // Hold reset and sweep every register pair through the read ports
  task automatic reset_check();
    tick(1, 0, 0, 0);
    check("rst_pc", pc, 32'd0);
    for (int k = 0; k < 16; k++) begin
      tick(1, 1, 0, f_r(2 * k, 2 * k + 1, 0, 0, 32));
      check("rst_reg1", reg1, 32'd0);
      check("rst_reg2", reg2, 32'd0);
      check("rst_pc_hold", pc, 32'd0);
    end
  endtask

  function automatic logic [31:0] rand_ins();
    int fns[11] = '{0, 2, 3, 8, 32, 34, 36, 37, 38, 39, 42};
    int iops[6] = '{8, 10, 12, 13, 14, 15};
    int k = $urandom_range(0, 10);
    int a = $urandom_range(0, 31);
    int b = $urandom_range(0, 31);
    int c = $urandom_range(0, 31);
    int s = $urandom_range(0, 31);
    int im = $urandom_range(0, 65535);
    case (k)
      0, 1, 2, 3: return f_r(a, b, c, s, fns[$urandom_range(0, 10)]);
      4, 5:       return f_i(iops[$urandom_range(0, 5)], a, b, im);
      6:          return f_i(35, a, b, im);
      7:          return f_i(43, a, b, im);
      8:          return f_i($urandom_range(4, 5), a, b, $urandom_range(0, 8) - 4);
      9:          return f_j($urandom_range(2, 3), int'($urandom));
      default:    return $urandom;
    endcase
  endfunction

  initial begin
    rstd = 1; imem_we = 0; imem_addr = 0; imem_wdata = 0;
    m_pc = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = 0;
    for (int i = 0; i < 256; i++) begin m_imem[i] = 0; m_dmem[i] = 0; end
    @(negedge clk);
    for (int i = 0; i < 256; i++) tick(1, 1, i, 0);
    chk_en = 1;
    reset_check();

    // ALU chain
    prog = {f_i(8, 0, 1, 5), f_i(8, 0, 2, 16'hfffd), f_r(1, 2, 3, 0, 32),
            f_r(2, 1, 4, 0, 42), f_r(2, 1, 5, 0, 34)};
    xpc  = {0, 1, 2, 3, 4};
    xwra = {1, 2, 3, 4, 5};
    xres = {32'd5, 32'hfffffffd, 32'd2, 32'd1, 32'hfffffff8};
    load_prog();
    run_lit("alu");

    // Logic, shifts and r0 protection
    prog = {f_i(15, 0, 1, 16'h1234), f_i(13, 1, 1, 16'h5678), f_i(15, 0, 3, 16'h8000),
            f_r(0, 3, 2, 4, 3), f_r(0, 3, 4, 4, 2), f_r(0, 1, 5, 4, 0),
            f_i(8, 0, 0, 7), f_r(0, 0, 7, 0, 32), f_i(14, 1, 8, 16'hffff),
            f_r(1, 0, 9, 0, 39), f_i(12, 1, 10, 16'hff0f), f_i(10, 2, 11, 16'hffff),
            f_r(1, 3, 12, 0, 37), f_r(1, 3, 13, 0, 36)};
    xpc  = {0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13};
    xwra = {1, 1, 3, 2, 4, 5, 0, 7, 8, 9, 10, 11, 12, 13};
    xres = {32'h12340000, 32'h12345678, 32'h80000000, 32'hf8000000, 32'h08000000,
            32'h23456780, 32'd0, 32'd0, 32'h1234a987, 32'hedcba987, 32'h00005608,
            32'd1, 32'h92345678, 32'd0};
    load_prog();
    run_lit("logic");

    // Store then load
    prog = {f_i(15, 0, 1, 16'hdead), f_i(13, 1, 1, 16'hbeef), f_i(43, 0, 1, 4),
            f_i(35, 0, 6, 4), f_r(0, 6, 7, 0, 34)};
    xpc  = {0, 1, 2, 3, 4};
    xwra = {1, 1, 0, 6, 7};
    xres = {32'hdead0000, 32'hdeadbeef, 32'd0, 32'hdeadbeef, 32'h21524111};
    load_prog();
    run_lit("mem");

    // Control flow
    prog = {};
    for (int i = 0; i < 33; i++) prog.push_back(f_i(8, 0, 9, 16'h0bad));
    prog[0]  = f_i(8, 0, 1, 1);
    prog[1]  = f_i(5, 1, 1, 5);
    prog[2]  = f_i(4, 0, 0, 2);
    prog[5]  = f_j(3, 32'h20);
    prog[6]  = f_i(4, 1, 1, 16'hffff);
    prog[32] = f_r(31, 0, 0, 0, 8);
    xpc  = {0, 1, 2, 5, 32'h20, 6, 6, 6};
    xwra = {1, 0, 0, 31, 0, 0, 0, 0};
    xres = {32'd1, 32'd0, 32'd0, 32'd6, 32'd0, 32'd0, 32'd0, 32'd0};
    load_prog();
    run_lit("ctl");

    reset_check();

    // Zero the whole data memory so random loads are predictable
    prog = {f_i(8, 0, 2, 256), f_i(43, 1, 0, 0), f_i(8, 1, 1, 1),
            f_i(5, 1, 2, 16'hfffd), f_i(4, 0, 0, 16'hffff)};
    load_prog();
    for (int i = 0; i < 780; i++) tick(0, 0, 0, 0);
    check("init_loop_pc", pc, 32'd4);

    // Random programs with occasional reloads and resets
    prog = {};
    for (int i = 0; i < 256; i++) prog.push_back(rand_ins());
    load_prog();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0)
        tick($urandom_range(0, 99) == 0, 1, $urandom_range(0, 255), rand_ins());
      else
        tick($urandom_range(0, 99) == 0, 0, 0, 0);
    end

    reset_check();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
